// File: rtl/bird_physics.sv
// bird_physics: fixed-point vertical physics for the player bird. Integrates gravity and
// flap impulses once per physics tick and detects ceiling, floor and pipe deaths.
module bird_physics #(
   parameter int Y_WIDTH       = 11,
   parameter int FRAC_BITS     = 4,
   parameter int VEL_WIDTH     = 12,
   parameter int SCREEN_HEIGHT = 768,
   parameter int BIRD_HEIGHT   = 50,
   parameter int START_Y       = 300,
   parameter int GRAVITY       = 16,
   parameter int JUMP_VELOCITY = -240,
   parameter int MAX_FALL      = 192,
   parameter int TICK_MAX      = 800000,
   parameter int CEILING_KILLS = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        game_rst,
   input  logic                        flap,
   input  logic                        pause,
   input  logic                        pipe_hit,
   output logic [Y_WIDTH-1:0]          bird_y,
   output logic signed [VEL_WIDTH-1:0] velocity,
   output logic                        collision,
   output logic [1:0]                  collision_src,
   output logic [1:0]                  state,
   output logic                        tick
);

   localparam int PW = Y_WIDTH + FRAC_BITS + 1;
   localparam int SW = ((PW > VEL_WIDTH) ? PW : VEL_WIDTH) + 1;
   localparam int XW = VEL_WIDTH + 2;
   localparam int CW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

   localparam logic signed [PW-1:0]        POS_START = PW'(START_Y << FRAC_BITS);
   localparam logic signed [SW-1:0]        FLOOR     = SW'((SCREEN_HEIGHT - BIRD_HEIGHT) << FRAC_BITS);
   localparam logic signed [VEL_WIDTH-1:0] JUMP_V    = VEL_WIDTH'(JUMP_VELOCITY);
   localparam logic signed [VEL_WIDTH-1:0] MAX_V     = VEL_WIDTH'(MAX_FALL);
   localparam logic signed [XW-1:0]        GRAV      = XW'(GRAVITY);
   localparam logic signed [XW-1:0]        SUM_HI    = {3'b000, {(VEL_WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0]        SUM_LO    = {3'b111, {(VEL_WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]               CNT_LAST  = CW'(TICK_MAX - 1);

   localparam logic [1:0] SRC_NONE  = 2'b00;
   localparam logic [1:0] SRC_CEIL  = 2'b01;
   localparam logic [1:0] SRC_FLOOR = 2'b10;
   localparam logic [1:0] SRC_PIPE  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_FLYING = 2'b01,
      S_DEAD   = 2'b10
   } state_e;

   state_e                        state_q, state_d;
   logic signed [PW-1:0]          pos_q, pos_d;
   logic signed [VEL_WIDTH-1:0]   vel_q, vel_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          pend_q, pend_d;
   logic                          tick_q, tick_d;
   logic                          coll_q, coll_d;
   logic [1:0]                    src_q, src_d;

   logic signed [XW-1:0]          vsum;
   logic signed [VEL_WIDTH-1:0]   vsat;
   logic signed [VEL_WIDTH-1:0]   vclamp;
   logic signed [VEL_WIDTH-1:0]   vnext;
   logic signed [SW-1:0]          pos_ext;
   logic signed [SW-1:0]          vel_ext;
   logic signed [SW-1:0]          psum;
   logic                          hit_floor;
   logic                          hit_ceil;

   // Tick arithmetic: saturate to the velocity range first, then apply terminal speed.
   always_comb begin
      vsum = {{2{vel_q[VEL_WIDTH-1]}}, vel_q} + GRAV;
      if (vsum > SUM_HI) begin
         vsat = SUM_HI[VEL_WIDTH-1:0];
      end else if (vsum < SUM_LO) begin
         vsat = SUM_LO[VEL_WIDTH-1:0];
      end else begin
         vsat = vsum[VEL_WIDTH-1:0];
      end
      vclamp    = (vsat > MAX_V) ? MAX_V : vsat;
      vnext     = (pend_q || flap) ? JUMP_V : vclamp;
      pos_ext   = {{(SW-PW){pos_q[PW-1]}}, pos_q};
      vel_ext   = {{(SW-VEL_WIDTH){vel_q[VEL_WIDTH-1]}}, vel_q};
      psum      = pos_ext + vel_ext;
      hit_floor = (psum >= FLOOR);
      hit_ceil  = psum[SW-1] || (psum == '0);
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      vel_d   = vel_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      tick_d  = 1'b0;
      coll_d  = coll_q;
      src_d   = src_q;

      if (game_rst) begin
         state_d = S_IDLE;
         pos_d   = POS_START;
         vel_d   = '0;
         cnt_d   = '0;
         pend_d  = 1'b0;
         coll_d  = 1'b0;
         src_d   = SRC_NONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_d  = '0;
               pend_d = 1'b0;
               if (flap) begin
                  state_d = S_FLYING;
                  vel_d   = JUMP_V;
               end
            end

            S_FLYING: begin
               pend_d = pend_q | flap;
               if (pipe_hit) begin
                  state_d = S_DEAD;
                  coll_d  = 1'b1;
                  src_d   = SRC_PIPE;
               end else if (!pause) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d  = '0;
                     pend_d = 1'b0;
                     tick_d = 1'b1;
                     if (hit_floor) begin
                        pos_d   = FLOOR[PW-1:0];
                        vel_d   = '0;
                        state_d = S_DEAD;
                        coll_d  = 1'b1;
                        src_d   = SRC_FLOOR;
                     end else if (hit_ceil) begin
                        pos_d = '0;
                        if (CEILING_KILLS != 0) begin
                           vel_d   = '0;
                           state_d = S_DEAD;
                           coll_d  = 1'b1;
                           src_d   = SRC_CEIL;
                        end else begin
                           vel_d = vnext[VEL_WIDTH-1] ? '0 : vnext;
                        end
                     end else begin
                        pos_d = psum[PW-1:0];
                        vel_d = vnext;
                     end
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end

            S_DEAD: begin
               coll_d = 1'b1;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pos_q   <= POS_START;
         vel_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         tick_q  <= 1'b0;
         coll_q  <= 1'b0;
         src_q   <= SRC_NONE;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         vel_q   <= vel_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         tick_q  <= tick_d;
         coll_q  <= coll_d;
         src_q   <= src_d;
      end
   end

   assign bird_y        = pos_q[FRAC_BITS +: Y_WIDTH];
   assign velocity      = vel_q;
   assign collision     = coll_q;
   assign collision_src = src_q;
   assign state         = state_q;
   assign tick          = tick_q;

endmodule
